seg7_display_arbiter: RTL and testbench
=======================================

Name: seg7_display_arbiter

Overview:
- Shares the single 4-digit 7-segment display between up to NUM_REQ requesters (e.g. lift height readout, fault code, menu value).
- Sits directly upstream of the display scan driver.
- Drives that driver's 16-bit hex value and enforces a minimum on-screen hold time so every value stays human-readable.
- Fixed priority: requester 0 is highest.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- HOLD_CYCLES, 50_000_000: minimum clk cycles an owner is displayed (1 s at 50 MHz); must be >= 2.
- MAX_OWN_CYCLES, 250_000_000: fairness limit in clk cycles, used only with SEG7_ARB_FAIR_EN.
- IDLE_VALUE, 16'h0000: value driven on bits_out when no owner.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request; bit i belongs to requester i.
- req_data  in  NUM_REQ*16  requester i value at [16*i+15:16*i].
- grant  out  NUM_REQ  one-hot current owner, or all zero.
- owner_id  out  $clog2(NUM_REQ)  index of owner; 0 when idle.
- active  out  1  high while any owner holds the display.
- bits_out  out  16  value to the display scan driver.

Behaviour:
- Reset is asynchronous and active-low.
- Reset values: grant=0, owner_id=0, active=0, bits_out=IDLE_VALUE, hold counter=0, state=IDLE.
- Reset asserted mid-operation clears everything immediately; no value is retained.
- FSM states:
  - IDLE: grant=0, bits_out=IDLE_VALUE. On any req sampled high at a clk edge, the highest-priority (lowest index) requester is granted. Transition to HOLD; grant, owner_id, active and bits_out all update at that same edge (1-cycle latency from req).
  - HOLD: counter runs from 0 (grant cycle) to HOLD_CYCLES-1. bits_out is registered from the owner's req_data each cycle while owner req=1. If owner drops req, bits_out freezes at the last sampled value and grant remains until the hold expires. Preemption is not allowed in HOLD. At the edge where counter = HOLD_CYCLES-1, transition to OWN.
  - OWN: re-arbitrated every cycle.
    - A higher-priority req present: switch to it (new grant, bits_out = its data, counter=0, state HOLD) in one edge.
    - Else owner req=1: stay in OWN, track data.
    - Else any lower req: switch to highest of those, state HOLD.
    - Else: go to IDLE; bits_out=IDLE_VALUE on that edge.
- Simultaneous events at hold expiry: evaluated with OWN rules in the same edge, i.e. the higher-priority requester wins over the owner's continued request.
- The counter is $clog2(HOLD_CYCLES) bits wide and saturates; it never wraps.
- grant is always one-hot or zero. owner_id always matches grant.

Optional Feature:
- Macro: SEG7_ARB_FAIR_EN.
- Defined:
  - An own-counter ($clog2(MAX_OWN_CYCLES) bits) counts cycles since grant and resets on every new grant.
  - When it reaches MAX_OWN_CYCLES-1 in OWN and any other req is high, the next lower-index-wrapping requester after owner_id is granted (round-robin step), state HOLD.
- Undefined: the owner keeps the display indefinitely unless preempted by higher priority. The own-counter logic is not present.

Decomposition:
- Package seg7_pkg holds:
  - SEG7_DW=16
  - SEG7_IDLE_VALUE default
  - arbiter state enum (IDLE, HOLD, OWN)
- Sub-module seg7_prio_enc: combinational priority encoder with a NUM_REQ mask input, producing a one-hot grant, an index and an any-valid flag. It is reused for both the fixed-priority and round-robin selections.

Test Plan:
All scenarios use NUM_REQ=4, HOLD_CYCLES=4, MAX_OWN_CYCLES=10.
- req=4'b0100, data2=16'h1234 -> next edge grant=0100, owner_id=2, active=1, bits_out=1234. Drop req after 8 cycles -> IDLE next edge, bits_out=0000.
- Owner 2 in HOLD, req0 rises with data0=16'hE001 at cycle 1 of hold -> no switch until hold expires (cycle 4 edge); then grant=0001, bits_out=E001.
- Owner 1 drops req at hold cycle 1, data1 was 16'h00AB -> bits_out stays 00AB and grant=0010 through cycle 3, then IDLE.
- rst_n pulsed low mid-HOLD, asynchronously between edges -> all outputs zero / IDLE_VALUE immediately without waiting for clk. After release, held req regranted on the next edge.
- With SEG7_ARB_FAIR_EN, req=4'b0011 held continuously -> owner 0 for 10 cycles, then grant=0010 for at least 4 cycles, then back to 0. Without the macro, owner 0 is kept forever.
- All four req rise in the same cycle from IDLE -> grant=0001. After req0 drops post-hold, grant=0010 on the next edge with a fresh 4-cycle hold.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display arbiter: data width, idle value
// and the arbiter state encoding.
package seg7_pkg;

    localparam int SEG7_DW = 16;
    localparam logic [SEG7_DW-1:0] SEG7_IDLE_VALUE = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OWN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/seg7_prio_enc.sv
// Masked fixed-priority encoder: the lowest-index request whose mask bit is set
// wins. Returns the winner as one-hot and as an index, plus a valid flag.
module seg7_prio_enc #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [N-1:0] masked;

    assign masked = req & mask;

    // Scan from the top down so that the lowest set index is the last one written.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Shares one 4-digit 7-segment display between NUM_REQ requesters with fixed
// priority and a minimum hold time. Define SEG7_ARB_FAIR_EN for round-robin fairness.
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int                 NUM_REQ        = 4,
    parameter int                 HOLD_CYCLES    = 50_000_000,
    parameter int                 MAX_OWN_CYCLES = 250_000_000,
    parameter logic [SEG7_DW-1:0] IDLE_VALUE     = SEG7_IDLE_VALUE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*SEG7_DW-1:0]   req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [$clog2(NUM_REQ)-1:0]   owner_id,
    output logic                         active,
    output logic [SEG7_DW-1:0]           bits_out
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int HCW = $clog2(HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("seg7_display_arbiter: NUM_REQ must be 2..8");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("seg7_display_arbiter: HOLD_CYCLES must be >= 2");
    end
    if (MAX_OWN_CYCLES < 2) begin : g_bad_max_own
        $error("seg7_display_arbiter: MAX_OWN_CYCLES must be >= 2");
    end

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_id_q, owner_id_d;
    logic                 active_q, active_d;
    logic [SEG7_DW-1:0]   bits_out_q, bits_out_d;
    logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;

    logic [SEG7_DW-1:0]   data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   mask_all, mask_hi, mask_lo;
    logic [NUM_REQ-1:0]   all_oh, hi_oh, lo_oh;
    logic [IW-1:0]        all_idx, hi_idx, lo_idx;
    logic                 all_valid, hi_valid, lo_valid;

    logic                 decide;
    logic                 take;
    logic [NUM_REQ-1:0]   take_oh;
    logic [IW-1:0]        take_idx;
    logic                 go_idle;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*SEG7_DW +: SEG7_DW];
        end
    end

    // hi = strictly higher priority than the owner, lo = strictly lower priority.
    always_comb begin
        mask_all = '1;
        mask_hi  = '0;
        mask_lo  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_hi[i] = (IW'(i) < owner_id_q);
            mask_lo[i] = (IW'(i) > owner_id_q);
        end
    end

    seg7_prio_enc #(.N(NUM_REQ), .IW(IW)) u_enc_all (
        .req    (req),
        .mask   (mask_all),
        .onehot (all_oh),
        .idx    (all_idx),
        .valid  (all_valid)
    );

    seg7_prio_enc #(.N(NUM_REQ), .IW(IW)) u_enc_hi (
        .req    (req),
        .mask   (mask_hi),
        .onehot (hi_oh),
        .idx    (hi_idx),
        .valid  (hi_valid)
    );

    seg7_prio_enc #(.N(NUM_REQ), .IW(IW)) u_enc_lo (
        .req    (req),
        .mask   (mask_lo),
        .onehot (lo_oh),
        .idx    (lo_idx),
        .valid  (lo_valid)
    );

`ifdef SEG7_ARB_FAIR_EN
    localparam int OCW = $clog2(MAX_OWN_CYCLES);
    localparam logic [OCW-1:0] OWN_LAST = OCW'(MAX_OWN_CYCLES - 1);

    logic [OCW-1:0]     own_cnt_q, own_cnt_d;
    logic               own_expired;
    logic               others_req;
    logic [NUM_REQ-1:0] rr_oh;
    logic [IW-1:0]      rr_idx;

    assign own_expired = (own_cnt_q == OWN_LAST);
    assign others_req  = |(req & ~grant_q);

    // Round-robin step: first requester above the owner, else wrap to the lowest index.
    assign rr_oh  = lo_valid ? lo_oh  : hi_oh;
    assign rr_idx = lo_valid ? lo_idx : hi_idx;

    always_comb begin
        own_cnt_d = (own_cnt_q == OWN_LAST) ? own_cnt_q : own_cnt_q + 1'b1;
        if (take || go_idle || state_q == ST_IDLE) begin
            own_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_cnt_q <= '0;
        end else begin
            own_cnt_q <= own_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_id_d = owner_id_q;
        active_d   = active_q;
        bits_out_d = bits_out_q;
        hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
        decide     = 1'b0;
        take       = 1'b0;
        take_oh    = '0;
        take_idx   = '0;
        go_idle    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = '0;
                if (all_valid) begin
                    take     = 1'b1;
                    take_oh  = all_oh;
                    take_idx = all_idx;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    decide = 1'b1;
                end else if (req[owner_id_q]) begin
                    bits_out_d = data_arr[owner_id_q];
                end
            end
            ST_OWN: begin
                decide = 1'b1;
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        // Re-arbitration once the hold has expired, including the expiry edge itself.
        if (decide) begin
            if (hi_valid) begin
                take     = 1'b1;
                take_oh  = hi_oh;
                take_idx = hi_idx;
            end
`ifdef SEG7_ARB_FAIR_EN
            else if (own_expired && others_req) begin
                take     = 1'b1;
                take_oh  = rr_oh;
                take_idx = rr_idx;
            end
`endif
            else if (req[owner_id_q]) begin
                state_d    = ST_OWN;
                bits_out_d = data_arr[owner_id_q];
            end else if (lo_valid) begin
                take     = 1'b1;
                take_oh  = lo_oh;
                take_idx = lo_idx;
            end else begin
                go_idle = 1'b1;
            end
        end

        if (take) begin
            state_d    = ST_HOLD;
            grant_d    = take_oh;
            owner_id_d = take_idx;
            active_d   = 1'b1;
            bits_out_d = data_arr[take_idx];
            hold_cnt_d = '0;
        end

        if (go_idle) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            owner_id_d = '0;
            active_d   = 1'b0;
            bits_out_d = IDLE_VALUE;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_id_q <= '0;
            active_q   <= 1'b0;
            bits_out_q <= IDLE_VALUE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_id_q <= owner_id_d;
            active_q   <= active_d;
            bits_out_q <= bits_out_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant    = grant_q;
    assign owner_id = owner_id_q;
    assign active   = active_q;
    assign bits_out = bits_out_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Self-checking bench for seg7_display_arbiter: directed scenarios plus random
// request traffic, compared every cycle against a cycle-count reference model.
module tb_seg7_display_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int HOLD     = 4;
    localparam int MAX_OWN  = 10;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*16-1:0] reqData;
    logic [NUM_REQ-1:0]    grant;
    logic [1:0]            ownerId;
    logic                  active;
    logic [15:0]           bitsOut;

    int checkCount;
    int errorCount;
    int cycleNum;

    // Reference model: current owner (-1 when idle), cycles since grant, shown value.
    int          mOwner;
    int          mSince;
    logic [15:0] mVal;

    seg7_display_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .HOLD_CYCLES    (HOLD),
        .MAX_OWN_CYCLES (MAX_OWN),
        .IDLE_VALUE     (16'h0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (reqData),
        .grant    (grant),
        .owner_id (ownerId),
        .active   (active),
        .bits_out (bitsOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycleNum, observed, expected);
        end
    endtask

    function automatic logic [15:0] dataOf(input int i);
        return reqData[16*i +: 16];
    endfunction

    task automatic modelReset();
        mOwner = -1;
        mSince = 0;
        mVal   = 16'h0000;
    endtask

    task automatic modelGrant(input int i);
        mOwner = i;
        mSince = 0;
        mVal   = dataOf(i);
    endtask

    // One clock edge of the arbitration rules, evaluated on the sampled inputs.
    task automatic modelStep();
        int pick;
        pick = -1;
        if (mOwner < 0) begin
            for (int i = 0; i < NUM_REQ; i++) if (req[i] && pick < 0) pick = i;
            if (pick >= 0) modelGrant(pick);
        end else if (mSince < HOLD - 1) begin
            if (req[mOwner]) mVal = dataOf(mOwner);
            mSince++;
        end else begin
            for (int i = 0; i < mOwner; i++) if (req[i] && pick < 0) pick = i;
`ifdef SEG7_ARB_FAIR_EN
            if (pick < 0 && mSince >= MAX_OWN - 1) begin
                for (int k = 1; k < NUM_REQ; k++) begin
                    int j;
                    j = (mOwner + k) % NUM_REQ;
                    if (req[j] && pick < 0) pick = j;
                end
            end
`endif
            if (pick < 0 && req[mOwner]) begin
                mVal = dataOf(mOwner);
                mSince++;
            end else begin
                if (pick < 0) begin
                    for (int i = mOwner + 1; i < NUM_REQ; i++) if (req[i] && pick < 0) pick = i;
                end
                if (pick >= 0) modelGrant(pick);
                else modelReset();
            end
        end
    endtask

    task automatic compareAll();
        logic [31:0] expGrant;
        expGrant = (mOwner < 0) ? 32'd0 : (32'd1 << mOwner);
        checkOutput("grant",    32'(grant),   expGrant);
        checkOutput("owner_id", 32'(ownerId), (mOwner < 0) ? 32'd0 : 32'(mOwner));
        checkOutput("active",   32'(active),  (mOwner < 0) ? 32'd0 : 32'd1);
        checkOutput("bits_out", 32'(bitsOut), 32'(mVal));
    endtask

    // Drive inputs on the falling edge, step the model on the rising edge, check just after.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*16-1:0] d);
        @(negedge clk);
        req     = r;
        reqData = d;
        @(posedge clk);
        cycleNum++;
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cycleNum++;
        modelStep();
        #1;
        compareAll();
    endtask

    // Reset asserted between edges must clear the outputs without waiting for a clock.
    task automatic midCycleReset();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        releaseReset();
    endtask

    initial begin
        logic [NUM_REQ-1:0]    r;
        logic [NUM_REQ*16-1:0] d;

        checkCount = 0;
        errorCount = 0;
        cycleNum   = 0;
        rst_n      = 1'b0;
        req        = '0;
        reqData    = '0;
        modelReset();
        #1;
        compareAll();
        repeat (2) @(negedge clk);
        releaseReset();

        // Single requester granted with one cycle latency, then idle after drop.
        d = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
        applyStimulus(4'b0100, d);
        checkOutput("t1_grant", 32'(grant), 32'h4);
        checkOutput("t1_bits", 32'(bitsOut), 32'h1234);
        repeat (8) applyStimulus(4'b0100, d);
        repeat (2) applyStimulus(4'b0000, d);
        checkOutput("t1_idle_bits", 32'(bitsOut), 32'h0);

        // Higher priority rises during hold: waits for hold expiry.
        d = {16'h0000, 16'h5555, 16'h0000, 16'hE001};
        applyStimulus(4'b0100, d);
        repeat (3) applyStimulus(4'b0101, d);
        checkOutput("t2_no_preempt", 32'(grant), 32'h4);
        applyStimulus(4'b0101, d);
        checkOutput("t2_switch", 32'(grant), 32'h1);
        checkOutput("t2_bits", 32'(bitsOut), 32'hE001);
        repeat (5) applyStimulus(4'b0101, d);
        repeat (6) applyStimulus(4'b0000, d);

        // Owner drops early: value freezes and grant is held to hold expiry.
        d = {16'h0000, 16'h0000, 16'h00AB, 16'h0000};
        applyStimulus(4'b0010, d);
        d[31:16] = 16'hFFFF;
        repeat (2) applyStimulus(4'b0000, d);
        checkOutput("t3_freeze", 32'(bitsOut), 32'h00AB);
        checkOutput("t3_grant", 32'(grant), 32'h2);
        repeat (3) applyStimulus(4'b0000, d);

        // Asynchronous reset mid-hold, then the held request is regranted.
        d = {16'h0000, 16'h7777, 16'h0000, 16'h0000};
        applyStimulus(4'b0100, d);
        applyStimulus(4'b0100, d);
        midCycleReset();
        checkOutput("t4_regrant", 32'(grant), 32'h4);
        repeat (3) applyStimulus(4'b0100, d);
        repeat (6) applyStimulus(4'b0000, d);

        // Two requesters held continuously: fairness behaviour depends on the build.
        d = {16'h0000, 16'h0000, 16'hBBBB, 16'hAAAA};
        repeat (30) applyStimulus(4'b0011, d);
        repeat (6) applyStimulus(4'b0000, d);

        // All requesters at once, then the top one leaves.
        d = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
        applyStimulus(4'b1111, d);
        checkOutput("t6_grant", 32'(grant), 32'h1);
        repeat (5) applyStimulus(4'b1111, d);
        applyStimulus(4'b1110, d);
        checkOutput("t6_next", 32'(grant), 32'h2);
        repeat (5) applyStimulus(4'b1110, d);
        repeat (8) applyStimulus(4'b0000, d);

        // Random traffic with slowly toggling requests and occasional resets.
        r = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if ($urandom_range(5) == 0) r[k] = ~r[k];
                if ($urandom_range(1) == 1) d[16*k +: 16] = 16'($urandom);
            end
            applyStimulus(r, d);
            if ($urandom_range(300) == 0) midCycleReset();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
